// File: rtl/islip_scheduler_if.sv
// Request/decision bundle between the VOQ request logic and the iSLIP scheduler.
// match_count is present only when ISLIP_MATCH_COUNT_EN is defined.
interface islip_scheduler_if #(
  parameter int N = 4
);
  logic                start;
  logic [N-1:0][N-1:0] req_in;
  logic [N-1:0][N-1:0] decision;
  logic                ready;
`ifdef ISLIP_MATCH_COUNT_EN
  logic [$clog2(N+1)-1:0] match_count;
`endif

  modport master (
    output start,
    output req_in,
    input  decision,
`ifdef ISLIP_MATCH_COUNT_EN
    input  match_count,
`endif
    input  ready
  );

  modport slave (
    input  start,
    input  req_in,
    output decision,
`ifdef ISLIP_MATCH_COUNT_EN
    output match_count,
`endif
    output ready
  );
endinterface

// File: rtl/islip_scheduler.sv
// N x N iSLIP crossbar scheduler: up to ITER grant/accept iterations per round, 2 cycles each.
// Optional match_count output is enabled by defining ISLIP_MATCH_COUNT_EN.
module islip_scheduler #(
  parameter int N    = 4,
  parameter int ITER = 4
) (
  input  logic clk,
  input  logic reset,
  islip_scheduler_if.slave bus
);
  localparam int unsigned NU = N;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;
`ifdef ISLIP_MATCH_COUNT_EN
  localparam int CW = $clog2(N + 1);
`endif

  typedef enum logic [1:0] {IDLE, GRANT, ACCEPT} state_t;
  state_t state, state_nx;

  logic [N-1:0][N-1:0]  req_q;       // [input][output]
  logic [N-1:0][N-1:0]  gnt_q;       // [output][input], one-hot per output
  logic [N-1:0][N-1:0]  gnt_nx;
  logic [N-1:0][N-1:0]  cand;        // [output][input] requests from unmatched inputs
  logic [N-1:0][N-1:0]  gvec;        // [input][output] grants seen by each input
  logic [N-1:0][N-1:0]  acc;         // [input][output], one-hot per input
  logic [N-1:0][N-1:0]  match_q, match_nx, decision_q;
  logic [N-1:0]         in_matched, out_matched, in_matched_nx, out_matched_nx;
  logic [N-1:0][PW-1:0] g_ptr, a_ptr;
  logic [IW-1:0]        iter;
  logic                 new_match, last_iter;
`ifdef ISLIP_MATCH_COUNT_EN
  logic [CW-1:0]        match_count_q;
`endif

  // First set bit of vec at or after ptr, wrapping modulo N by compare-and-subtract.
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] vec, input logic [PW-1:0] ptr);
    logic [N-1:0] pick;
    logic         found;
    int unsigned  idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NU; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NU) idx = idx - NU;
      if (!found && vec[idx[PW-1:0]]) begin
        pick[idx[PW-1:0]] = 1'b1;
        found             = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [PW-1:0] wrap_inc(input int unsigned v);
    return (v == NU - 1) ? '0 : PW'(v + 1);
  endfunction

`ifdef ISLIP_MATCH_COUNT_EN
  function automatic logic [CW-1:0] popcount(input logic [N-1:0][N-1:0] m);
    int unsigned sum;
    sum = 0;
    for (int unsigned i = 0; i < NU; i++)
      for (int unsigned j = 0; j < NU; j++)
        sum = sum + 32'(m[i][j]);
    return CW'(sum);
  endfunction
`endif

  // Grant and accept arbitration over the registered request snapshot.
  always_comb begin
    cand   = '0;
    gvec   = '0;
    gnt_nx = '0;
    acc    = '0;
    for (int unsigned j = 0; j < NU; j++)
      for (int unsigned i = 0; i < NU; i++)
        cand[j][i] = req_q[i][j] & ~in_matched[i];
    for (int unsigned j = 0; j < NU; j++)
      if (!out_matched[j]) gnt_nx[j] = rr_pick(cand[j], g_ptr[j]);
    for (int unsigned i = 0; i < NU; i++)
      for (int unsigned j = 0; j < NU; j++)
        gvec[i][j] = gnt_q[j][i];
    for (int unsigned i = 0; i < NU; i++)
      if (!in_matched[i]) acc[i] = rr_pick(gvec[i], a_ptr[i]);
  end

  always_comb begin
    match_nx       = match_q | acc;
    new_match      = |acc;
    in_matched_nx  = in_matched;
    out_matched_nx = out_matched;
    for (int unsigned i = 0; i < NU; i++)
      for (int unsigned j = 0; j < NU; j++)
        if (acc[i][j]) begin
          in_matched_nx[i]  = 1'b1;
          out_matched_nx[j] = 1'b1;
        end
    last_iter = (iter == IW'(ITER - 1)) || !new_match;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = GRANT;
      GRANT:   state_nx = ACCEPT;
      ACCEPT:  state_nx = last_iter ? IDLE : GRANT;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q       <= '0;
      gnt_q       <= '0;
      match_q     <= '0;
      in_matched  <= '0;
      out_matched <= '0;
      decision_q  <= '0;
      g_ptr       <= '0;
      a_ptr       <= '0;
      iter        <= '0;
`ifdef ISLIP_MATCH_COUNT_EN
      match_count_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          req_q       <= bus.req_in;
          match_q     <= '0;
          in_matched  <= '0;
          out_matched <= '0;
          iter        <= '0;
        end
        GRANT: gnt_q <= gnt_nx;
        ACCEPT: begin
          match_q     <= match_nx;
          in_matched  <= in_matched_nx;
          out_matched <= out_matched_nx;
          // Pointers move only on first-iteration accepts, which keeps them desynchronised.
          if (iter == '0) begin
            for (int unsigned i = 0; i < NU; i++)
              for (int unsigned j = 0; j < NU; j++)
                if (acc[i][j]) begin
                  g_ptr[j] <= wrap_inc(i);
                  a_ptr[i] <= wrap_inc(j);
                end
          end
          if (last_iter) begin
            decision_q <= match_nx;
`ifdef ISLIP_MATCH_COUNT_EN
            match_count_q <= popcount(match_nx);
`endif
          end else begin
            iter <= iter + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready    = (state == IDLE);
  assign bus.decision = decision_q;
`ifdef ISLIP_MATCH_COUNT_EN
  assign bus.match_count = match_count_q;
`endif

endmodule

// File: tb/tb_islip_scheduler.sv
// Self-checking bench for islip_scheduler: directed plan rounds plus random rounds against
// an array-based iSLIP reference model.
module tb_islip_scheduler;
  localparam int N    = 4;
  localparam int ITER = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  islip_scheduler_if #(.N(N)) bus ();
  islip_scheduler_if #(.N(N)) bus1 ();

  islip_scheduler #(.N(N), .ITER(ITER)) dut  (.clk(clk), .reset(reset), .bus(bus));
  islip_scheduler #(.N(N), .ITER(1))    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  int n_cmp = 0;
  int n_bad = 0;
  int gp[N];
  int ap[N];
  logic [N-1:0][N-1:0] prev_d;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0][N-1:0] rand_req(input int pct);
    logic [N-1:0][N-1:0] r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        r[i][j] = ($urandom_range(0, 99) < pct);
    return r;
  endfunction

  // Reference iSLIP round over integer pointer arrays; m = iterations executed.
  task automatic model_round(input logic [N-1:0][N-1:0] r, output logic [N-1:0][N-1:0] d,
                             output int m);
    bit in_m[N];
    bit out_m[N];
    int grant_to[N];
    int added;
    bit done;
    d = '0;
    m = 0;
    done = 0;
    for (int k = 0; k < N; k++) begin
      in_m[k]  = 0;
      out_m[k] = 0;
    end
    for (int it = 0; it < ITER && !done; it++) begin
      m++;
      for (int oj = 0; oj < N; oj++) begin
        grant_to[oj] = -1;
        if (!out_m[oj])
          for (int k = 0; k < N; k++) begin
            int cand_i;
            cand_i = (gp[oj] + k) % N;
            if (grant_to[oj] < 0 && !in_m[cand_i] && r[cand_i][oj]) grant_to[oj] = cand_i;
          end
      end
      added = 0;
      for (int ii = 0; ii < N; ii++) begin
        int pick;
        pick = -1;
        if (!in_m[ii])
          for (int k = 0; k < N; k++) begin
            int cand_j;
            cand_j = (ap[ii] + k) % N;
            if (pick < 0 && grant_to[cand_j] == ii) pick = cand_j;
          end
        if (pick >= 0) begin
          d[ii][pick] = 1'b1;
          in_m[ii]    = 1;
          out_m[pick] = 1;
          added++;
          if (it == 0) begin
            gp[pick] = (ii + 1) % N;
            ap[ii]   = (pick + 1) % N;
          end
        end
      end
      if (added == 0) done = 1;
    end
  endtask

  task automatic check_ptrs(input string name);
    for (int j = 0; j < N; j++) begin
      check_eq($sformatf("%s.g%0d", name, j), 32'(dut.g_ptr[j]), gp[j]);
      check_eq($sformatf("%s.a%0d", name, j), 32'(dut.a_ptr[j]), ap[j]);
    end
  endtask

  task automatic run_round(input logic [N-1:0][N-1:0] r, input bit hold, input string name);
    logic [N-1:0][N-1:0] exp_d;
    int m;
    int lat;
    model_round(r, exp_d, m);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.req_in = r;
    @(posedge clk);
    #1;
    check_eq({name, ".busy"}, 32'(bus.ready), 0);
    lat = 0;
    do begin
      if (!bus.ready) check_eq({name, ".hold_dec"}, 32'(bus.decision), 32'(prev_d));
      @(negedge clk);
      bus.start  = hold;
      bus.req_in = rand_req(50);
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.ready && lat < 4 * ITER + 4);
    check_eq({name, ".latency"}, lat, 2 * m);
    check_eq({name, ".decision"}, 32'(bus.decision), 32'(exp_d));
`ifdef ISLIP_MATCH_COUNT_EN
    check_eq({name, ".match_count"}, 32'(bus.match_count), $countones(exp_d));
`endif
    check_ptrs(name);
    prev_d = exp_d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0][N-1:0] r;
    for (int k = 0; k < N; k++) begin
      gp[k] = 0;
      ap[k] = 0;
    end
    prev_d      = '0;
    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.req_in  = '0;
    bus1.start  = 1'b0;
    bus1.req_in = '0;
    #1;
    check_eq("rst.ready", 32'(bus.ready), 1);
    check_eq("rst.decision", 32'(bus.decision), 0);
`ifdef ISLIP_MATCH_COUNT_EN
    check_eq("rst.match_count", 32'(bus.match_count), 0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_ptrs("rst");

    // Back-to-back all-ones rounds: start held high through the first round.
    run_round('1, 1'b1, "ones1");
    check_eq("plan.ones1", 32'(bus.decision), 32'h8421);
    run_round('1, 1'b0, "ones2");
    check_eq("plan.ones2", 32'(bus.decision), 32'h8412);

    run_round('0, 1'b0, "zero");
    check_eq("plan.zero", 32'(bus.decision), 0);

    r = '0;
    for (int i = 0; i < N; i++) r[i][N-1-i] = 1'b1;
    run_round(r, 1'b0, "anti");
    check_eq("plan.anti", 32'(bus.decision), 32'h1248);

    for (int t = 0; t < 40; t++) begin
      bit hold;
      hold = (t != 39) && ($urandom_range(0, 1) == 1);
      run_round(rand_req($urandom_range(10, 90)), hold, $sformatf("rnd%0d", t));
    end

    // Asynchronous reset while the first ACCEPT is in progress.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.req_in = '1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      gp[k] = 0;
      ap[k] = 0;
    end
    prev_d = '0;
    check_eq("midrst.ready", 32'(bus.ready), 1);
    check_eq("midrst.decision", 32'(bus.decision), 0);
`ifdef ISLIP_MATCH_COUNT_EN
    check_eq("midrst.match_count", 32'(bus.match_count), 0);
`endif
    check_ptrs("midrst");
    @(negedge clk);
    reset = 1'b1;
    run_round('1, 1'b0, "after_rst");
    check_eq("plan.after_rst", 32'(bus.decision), 32'h8421);

    // ITER=1 instance: all-ones yields the single match 0->0 after 2 cycles.
    @(negedge clk);
    bus1.start  = 1'b1;
    bus1.req_in = '1;
    @(posedge clk);
    #1;
    check_eq("iter1.busy0", 32'(bus1.ready), 0);
    @(negedge clk);
    bus1.start = 1'b0;
    @(posedge clk);
    #1;
    check_eq("iter1.busy1", 32'(bus1.ready), 0);
    @(posedge clk);
    #1;
    check_eq("iter1.ready", 32'(bus1.ready), 1);
    check_eq("iter1.decision", 32'(bus1.decision), 32'h0001);
`ifdef ISLIP_MATCH_COUNT_EN
    check_eq("iter1.match_count", 32'(bus1.match_count), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
